// File: rtl/stepper_pio_pkg.sv
// Shared constants for the stepper PIO blocks: the Avalon word address map and the
// edge-capture selection codes.
package stepper_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Widens a debounced input vector to a bus word, zero-filling the upper bits.
    function automatic logic [31:0] pio_zext(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                result[i] = value[i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stepper_pio_key_in_debounce.sv
// Single-bit input conditioner: a two-flop synchroniser followed by a counter that
// accepts a new level only after it has held for DEBOUNCE_CYCLES consecutive clocks.
module pio_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_deb
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
            r_deb   <= RESET_VAL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            // Any return to the accepted level throws away the partial count.
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/stepper_pio_key_in.sv
// Avalon-MM input PIO for push-buttons and limit switches: debounced inputs, selectable
// edge capture with write-1-to-clear, and a maskable level interrupt.
module stepper_pio_key_in
    import stepper_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr_en;
    logic [31:0]      w_read_mux;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            pio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (RESET_LEVEL[gi])
            ) u_debounce (
                .clk     (clk),
                .reset   (reset),
                .i_async (in_port[gi]),
                .o_deb   (w_deb[gi])
            );
        end

        if (EDGE_TYPE == EDGE_RISING) begin : g_rise
            assign w_event = w_deb & ~r_deb_d;
        end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign w_event = ~w_deb & r_deb_d;
        end else begin : g_any
            assign w_event = w_deb ^ r_deb_d;
        end
    endgenerate

    assign w_wr_en = chipselect && !write_n;
    assign w_wdata = writedata[WIDTH-1:0];
    // Bits above WIDTH have no storage behind them.
    assign w_unused_wdata = ^writedata;

    always_comb begin
        w_read_mux = '0;
        case (address)
            PIO_ADDR_DATA:    w_read_mux = pio_zext(32'(w_deb), WIDTH);
            PIO_ADDR_DIR:     w_read_mux = '0;
            PIO_ADDR_IRQMASK: w_read_mux = pio_zext(32'(r_irqmask), WIDTH);
            PIO_ADDR_EDGECAP: w_read_mux = pio_zext(32'(r_edgecap), WIDTH);
            default:          w_read_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb_d    <= RESET_LEVEL;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
        end else begin
            r_deb_d    <= w_deb;
            r_readdata <= chipselect ? w_read_mux : 32'd0;

            if (w_wr_en && address == PIO_ADDR_IRQMASK) begin
                r_irqmask <= w_wdata;
            end

            // A fresh event on a bit overrides a simultaneous clear of that bit.
            if (w_wr_en && address == PIO_ADDR_EDGECAP) begin
                r_edgecap <= (r_edgecap & ~w_wdata) | w_event;
            end else begin
                r_edgecap <= r_edgecap | w_event;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_stepper_pio_key_in.sv
// Directed bench for stepper_pio_key_in with a short debounce window and falling-edge capture.
module tb_stepper_pio_key_in;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int          pass_cnt;
    int          check_cnt;
    logic [31:0] rd;

    stepper_pio_key_in #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (1),
        .RESET_LEVEL     (4'hF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end on a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
        $display("read  addr=%0d data=%h", a, d);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check_cnt++; if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); else pass_cnt++;
        check_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else pass_cnt++;
        bus_read(2'd0, rd);
        check_cnt++; if (rd !== 32'h0000000F) $display("FAIL reset_data: got %h expected %h", rd, 32'hF); else pass_cnt++;
        bus_read(2'd1, rd);
        check_cnt++; if (rd !== 32'h0) $display("FAIL reset_dir: got %h expected %h", rd, 32'h0); else pass_cnt++;
        bus_read(2'd2, rd);
        check_cnt++; if (rd !== 32'h0) $display("FAIL reset_mask: got %h expected %h", rd, 32'h0); else pass_cnt++;
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h0) $display("FAIL reset_edgecap: got %h expected %h", rd, 32'h0); else pass_cnt++;
    endtask

    task automatic test_falling_capture;
        in_port    = 4'hD;
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check_cnt++; if (readdata !== 32'hF) $display("FAIL data_before_accept: got %h expected %h", readdata, 32'hF); else pass_cnt++;
            end
            if (k == 7) begin
                check_cnt++; if (readdata !== 32'hD) $display("FAIL data_after_accept: got %h expected %h", readdata, 32'hD); else pass_cnt++;
            end
        end
        address = 2'd3;
        @(negedge clk);
        chipselect = 1'b0;
        check_cnt++; if (readdata !== 32'h2) $display("FAIL edgecap_bit1: got %h expected %h", readdata, 32'h2); else pass_cnt++;
        check_cnt++; if (irq !== 1'b0) $display("FAIL irq_masked: got %b expected 0", irq); else pass_cnt++;
        bus_write(2'd2, 32'h2);
        check_cnt++; if (irq !== 1'b1) $display("FAIL irq_after_mask: got %b expected 1", irq); else pass_cnt++;
        bus_read(2'd2, rd);
        check_cnt++; if (rd !== 32'h2) $display("FAIL mask_readback: got %h expected %h", rd, 32'h2); else pass_cnt++;
    endtask

    task automatic test_glitch_reject;
        in_port = 4'hF;
        tick(10);
        bus_read(2'd0, rd);
        check_cnt++; if (rd !== 32'hF) $display("FAIL data_release: got %h expected %h", rd, 32'hF); else pass_cnt++;
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h2) $display("FAIL rising_ignored: got %h expected %h", rd, 32'h2); else pass_cnt++;
        in_port = 4'hE;
        tick(3);
        in_port = 4'hF;
        tick(10);
        bus_read(2'd0, rd);
        check_cnt++; if (rd !== 32'hF) $display("FAIL glitch3_data: got %h expected %h", rd, 32'hF); else pass_cnt++;
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h2) $display("FAIL glitch3_edgecap: got %h expected %h", rd, 32'h2); else pass_cnt++;
        in_port = 4'hE;
        tick(4);
        in_port = 4'hF;
        tick(12);
        bus_read(2'd0, rd);
        check_cnt++; if (rd !== 32'hF) $display("FAIL pulse4_data: got %h expected %h", rd, 32'hF); else pass_cnt++;
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h3) $display("FAIL pulse4_edgecap: got %h expected %h", rd, 32'h3); else pass_cnt++;
    endtask

    task automatic test_w1c_mask;
        in_port = 4'hB;
        tick(10);
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h7) $display("FAIL edgecap_bit2: got %h expected %h", rd, 32'h7); else pass_cnt++;
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h6) $display("FAIL w1c_bit0: got %h expected %h", rd, 32'h6); else pass_cnt++;
        check_cnt++; if (irq !== 1'b1) $display("FAIL irq_still_set: got %b expected 1", irq); else pass_cnt++;
        bus_write(2'd3, 32'h2);
        check_cnt++; if (irq !== 1'b0) $display("FAIL irq_after_w1c: got %b expected 0", irq); else pass_cnt++;
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h4) $display("FAIL w1c_bit1: got %h expected %h", rd, 32'h4); else pass_cnt++;
        bus_write(2'd2, 32'hFFFFFFFF);
        check_cnt++; if (irq !== 1'b1) $display("FAIL irq_full_mask: got %b expected 1", irq); else pass_cnt++;
        bus_read(2'd2, rd);
        check_cnt++; if (rd !== 32'hF) $display("FAIL mask_truncate: got %h expected %h", rd, 32'hF); else pass_cnt++;
        bus_write(2'd0, 32'h0);
        bus_read(2'd0, rd);
        check_cnt++; if (rd !== 32'hB) $display("FAIL data_write_ignored: got %h expected %h", rd, 32'hB); else pass_cnt++;
        bus_write(2'd1, 32'hFFFFFFFF);
        bus_read(2'd1, rd);
        check_cnt++; if (rd !== 32'h0) $display("FAIL dir_reads_zero: got %h expected %h", rd, 32'h0); else pass_cnt++;
    endtask

    task automatic test_w1c_collision;
        in_port = 4'hF;
        tick(10);
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h4) $display("FAIL pre_collision: got %h expected %h", rd, 32'h4); else pass_cnt++;
        in_port = 4'hB;
        tick(6);
        // The bit2 event is live during this cycle, so the clear lands on the capture edge.
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h4) $display("FAIL set_wins: got %h expected %h", rd, 32'h4); else pass_cnt++;
        check_cnt++; if (irq !== 1'b1) $display("FAIL collision_irq: got %b expected 1", irq); else pass_cnt++;
    endtask

    task automatic test_reset_mid_debounce;
        in_port = 4'hF;
        tick(10);
        in_port = 4'h7;
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cnt++; if (irq !== 1'b0) $display("FAIL irq_after_reset: got %b expected 0", irq); else pass_cnt++;
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        for (int k = 4; k <= 10; k++) begin
            @(negedge clk);
            if (k == 4 || k == 9) begin
                check_cnt++; if (readdata !== 32'hF) $display("FAIL data_restart_k%0d: got %h expected %h", k, readdata, 32'hF); else pass_cnt++;
            end
            if (k == 10) begin
                check_cnt++; if (readdata !== 32'h7) $display("FAIL data_bit3_low: got %h expected %h", readdata, 32'h7); else pass_cnt++;
            end
        end
        address = 2'd3;
        @(negedge clk);
        chipselect = 1'b0;
        check_cnt++; if (readdata !== 32'h8) $display("FAIL edgecap_bit3: got %h expected %h", readdata, 32'h8); else pass_cnt++;
        tick(10);
        bus_read(2'd3, rd);
        check_cnt++; if (rd !== 32'h8) $display("FAIL captured_once: got %h expected %h", rd, 32'h8); else pass_cnt++;
        bus_read(2'd2, rd);
        check_cnt++; if (rd !== 32'h0) $display("FAIL mask_after_reset: got %h expected %h", rd, 32'h0); else pass_cnt++;
        check_cnt++; if (irq !== 1'b0) $display("FAIL irq_unmasked_cap: got %b expected 0", irq); else pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        check_cnt  = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'hF;
        @(negedge clk);
        test_reset;
        test_falling_capture;
        test_glitch_reject;
        test_w1c_mask;
        test_w1c_collision;
        test_reset_mid_debounce;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
